mul_issue_ctrl: RTL and testbench

- Issue/writeback controller that sits directly upstream and downstream of the multicycle `mul` unit in the single-cycle CPU.
- Accepts a decoded MUL/MULH instruction and latches its operands.
- Holds the operands stable on the multiplier inputs while stalling the PC/pipeline.
- Samples the multiplier's combinational valid, then retires the result to the register file in one writeback cycle.

---
 rtl/mul_ctrl_pkg.sv | 22 ++
 rtl/mul_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the multiply issue/writeback controller.
//   state_t : controller FSM states (IDLE, BUSY, WB), 2-bit encoding
//   op_t    : multiply flavour, OP_MUL selects the low product word,
//             OP_MULH selects the high product word
//   REG_ADDR_W / XLEN : register-file address width and datapath width
package mul_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef enum logic {
    OP_MUL  = 1'b0,
    OP_MULH = 1'b1
  } op_t;

endpackage

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback controller wrapped around the multicycle multiplier.
// Latches a decoded MUL/MULH, holds the operands on the multiplier while
// the pipeline is stalled, then retires the selected product word to the
// register file in a single writeback cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             current instruction is a multiply
//   op                0 = MUL (low word), 1 = MULH (high word)
//   rs1_val, rs2_val  signed operands
//   rd_addr           destination register
//   mul_a, mul_b      operands to the multiplier (zero unless BUSY)
//   mul_ab, mul_vld   signed product and its valid, from the multiplier
//   stall             freezes PC / normal regfile write
//   rf_we, rf_waddr, rf_wdata   multiply-result writeback
//   err               sticky timeout flag
module mul_issue_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int  MAX_WAIT = 65536,
  localparam int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [XLEN-1:0]       rs1_val,
  input  logic [XLEN-1:0]       rs2_val,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       mul_a,
  output logic [XLEN-1:0]       mul_b,
  input  logic [2*XLEN-1:0]     mul_ab,
  input  logic                  mul_vld,
  output logic                  stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  err
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  state_t                state_q, state_d;
  logic [XLEN-1:0]       a_q, a_d;
  logic [XLEN-1:0]       b_q, b_d;
  logic [XLEN-1:0]       res_q, res_d;
  op_t                   op_q, op_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  tout_q, tout_d;

  // State and datapath registers; everything returns to zero on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
    end
  end

  // Next state. A valid result wins over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (mul_vld || (cnt_q == LAST_WAIT)) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, wait counter, result capture and timeout bookkeeping.
  // tout_q remembers that the current operation expired so its WB cycle
  // retires without a write, while err_q stays set until reset.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    op_d   = op_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    tout_d = tout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = rs1_val;
          b_d    = rs2_val;
          op_d   = op_t'(op);
          rd_d   = rd_addr;
          cnt_d  = '0;
          tout_d = 1'b0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mul_vld) begin
          res_d = (op_q == OP_MULH) ? mul_ab[2*XLEN-1:XLEN] : mul_ab[XLEN-1:0];
        end else if (cnt_q == LAST_WAIT) begin
          err_d  = 1'b1;
          tout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs. The multiplier sees zeros outside BUSY so its internal
  // counter stays parked; stall follows start in IDLE so the multiply
  // instruction is held from its very first cycle.
  always_comb begin
    mul_a    = '0;
    mul_b    = '0;
    stall    = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = rd_q;
    rf_wdata = res_q;
    err      = err_q;
    case (state_q)
      IDLE: stall = start;
      BUSY: begin
        mul_a = a_q;
        mul_b = b_q;
        stall = 1'b1;
      end
      WB:      rf_we = ~tout_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: two instances (default MAX_WAIT and MAX_WAIT = 8)
// share one stimulus stream, each driven by a small behavioural multiplier
// that reports valid after min(|a|,|b|) BUSY cycles.
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_addr;

  logic [31:0] mul_a [2];
  logic [31:0] mul_b [2];
  logic [63:0] mul_ab [2];
  logic        mul_vld [2];
  logic        stall [2];
  logic        rf_we [2];
  logic [4:0]  rf_waddr [2];
  logic [31:0] rf_wdata [2];
  logic        err [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.MAX_WAIT(65536)) dut0 (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_ab(mul_ab[0]), .mul_vld(mul_vld[0]),
    .stall(stall[0]), .rf_we(rf_we[0]), .rf_waddr(rf_waddr[0]),
    .rf_wdata(rf_wdata[0]), .err(err[0])
  );

  mul_issue_ctrl #(.MAX_WAIT(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_ab(mul_ab[1]), .mul_vld(mul_vld[1]),
    .stall(stall[1]), .rf_we(rf_we[1]), .rf_waddr(rf_waddr[1]),
    .rf_wdata(rf_wdata[1]), .err(err[1])
  );

  function automatic longint absv(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic longint minabs(input logic [31:0] a, input logic [31:0] b);
    return (absv(a) < absv(b)) ? absv(a) : absv(b);
  endfunction

  // Behavioural multiplier: counter parks at 0 while both inputs are zero.
  longint mcnt [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || (mul_a[i] == 32'd0 && mul_b[i] == 32'd0)) mcnt[i] <= 0;
      else mcnt[i] <= mcnt[i] + 1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_mul
    assign mul_ab[g]  = $signed({{32{mul_a[g][31]}}, mul_a[g]}) *
                        $signed({{32{mul_b[g][31]}}, mul_b[g]});
    assign mul_vld[g] = (mcnt[g] >= minabs(mul_a[g], mul_b[g]));
  end

  task automatic checkOutput(input string name, input int idx,
                             input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h (cycle %0d)",
               name, idx, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] a,
                               input logic [31:0] b, input logic o,
                               input logic [4:0] rd);
    start   = s;
    rs1_val = a;
    rs2_val = b;
    op      = o;
    rd_addr = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: an accepted multiply at cycle T with
  // me = min(min(|a|,|b|), MAX_WAIT-1) stalls for T..T+me+1, writes back at
  // T+me+2 (unless it timed out) and frees the unit from T+me+3.
  int          mw [2] = '{65536, 8};
  logic        act [2];
  int          t0 [2];
  logic [31:0] ma [2];
  logic [31:0] mb [2];
  logic        mop [2];
  logic [4:0]  mrd [2];
  logic        merr [2];
  logic        model_on = 1'b0;

  initial begin
    longint      m, me;
    logic        to;
    logic [63:0] prod;
    logic [31:0] word;
    logic        e_stall, e_we;
    logic [31:0] e_a, e_b;
    int          d;
    forever begin
      @(negedge clk);
      if (!model_on) begin
        if (rst) begin
          model_on = 1'b1;
          for (int i = 0; i < 2; i++) begin act[i] = 1'b0; merr[i] = 1'b0; t0[i] = 0; end
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          m  = minabs(ma[i], mb[i]);
          to = (m > longint'(mw[i] - 1));
          me = to ? longint'(mw[i] - 1) : m;
          d  = cyc - t0[i];
          if (act[i] && d >= me + 3) act[i] = 1'b0;
          if (!act[i]) begin
            e_stall = start; e_a = 0; e_b = 0; e_we = 1'b0;
          end else if (d <= me + 1) begin
            e_stall = 1'b1; e_a = ma[i]; e_b = mb[i]; e_we = 1'b0;
          end else begin
            e_stall = 1'b0; e_a = 0; e_b = 0; e_we = ~to;
            if (to) merr[i] = 1'b1;
          end
          checkOutput("stall", i, stall[i], e_stall);
          checkOutput("mul_a", i, mul_a[i], e_a);
          checkOutput("mul_b", i, mul_b[i], e_b);
          checkOutput("rf_we", i, rf_we[i], e_we);
          if (act[i] && d == me + 2 && !to) begin
            prod = longint'($signed(ma[i])) * longint'($signed(mb[i]));
            word = mop[i] ? prod[63:32] : prod[31:0];
            checkOutput("rf_waddr", i, rf_waddr[i], mrd[i]);
            checkOutput("rf_wdata", i, rf_wdata[i], word);
          end
          checkOutput("err", i, err[i], merr[i]);
          if (rst) begin
            act[i] = 1'b0; merr[i] = 1'b0;
          end else if (!act[i] && start) begin
            act[i] = 1'b1; t0[i] = cyc;
            ma[i] = rs1_val; mb[i] = rs2_val; mop[i] = op; mrd[i] = rd_addr;
          end
        end
      end
      cyc++;
    end
  end

  // Directed sequences with hand-computed literal expectations.
  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    step(); step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_stall", i, stall[i], 0);
      checkOutput("rst_mul_a", i, mul_a[i], 0);
      checkOutput("rst_rf_we", i, rf_we[i], 0);
      checkOutput("rst_waddr", i, rf_waddr[i], 0);
      checkOutput("rst_wdata", i, rf_wdata[i], 0);
      checkOutput("rst_err", i, err[i], 0);
    end
    step(); rst = 1'b0;
    step();

    // 7 x 3, start held through WB (must be ignored there)
    step(); applyStimulus(1, 7, 3, 0, 5);
    for (int d = 0; d <= 6; d++) begin
      if (d > 0) step();
      if (d == 6) start = 1'b0;
      @(negedge clk);
      if (d == 4) checkOutput("t1_stall_T4", 0, stall[0], 1);
      if (d == 5) begin
        checkOutput("t1_we", 0, rf_we[0], 1);
        checkOutput("t1_waddr", 0, rf_waddr[0], 5);
        checkOutput("t1_wdata", 0, rf_wdata[0], 32'h15);
        checkOutput("t1_stall_wb", 0, stall[0], 0);
      end
      if (d == 6) checkOutput("t1_idle_we", 0, rf_we[0], 0);
    end

    // 7 x -3 MUL then MULH back-to-back, start held high continuously
    step(); applyStimulus(1, 7, 32'hFFFF_FFFD, 0, 9);
    for (int d = 0; d <= 13; d++) begin
      if (d > 0) step();
      if (d == 5) op = 1'b1;
      if (d == 7) start = 1'b0;
      @(negedge clk);
      if (d == 5) begin
        checkOutput("t2_mul_we", 0, rf_we[0], 1);
        checkOutput("t2_mul_wdata", 0, rf_wdata[0], 32'hFFFF_FFEB);
      end
      if (d == 7) checkOutput("t2_mulh_busy_a", 0, mul_a[0], 7);
      if (d == 11) begin
        checkOutput("t2_mulh_we", 0, rf_we[0], 1);
        checkOutput("t2_mulh_wdata", 1, rf_wdata[1], 32'hFFFF_FFFF);
      end
    end

    // 0 x 0x12345678: a single BUSY cycle
    step(); applyStimulus(1, 0, 32'h1234_5678, 0, 3);
    for (int d = 0; d <= 3; d++) begin
      if (d > 0) step();
      if (d == 1) start = 1'b0;
      @(negedge clk);
      if (d == 1) checkOutput("t3_mul_b", 0, mul_b[0], 32'h1234_5678);
      if (d == 2) begin
        checkOutput("t3_we", 0, rf_we[0], 1);
        checkOutput("t3_wdata", 0, rf_wdata[0], 0);
      end
    end

    // 5 x 4 with the input buses scrambled during BUSY
    step(); applyStimulus(1, 5, 4, 0, 7);
    for (int d = 0; d <= 7; d++) begin
      if (d > 0) step();
      if (d >= 1 && d <= 5)
        applyStimulus(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      if (d == 6) applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      if (d >= 1 && d <= 5) begin
        checkOutput("t4_hold_a", 0, mul_a[0], 5);
        checkOutput("t4_hold_b", 0, mul_b[0], 4);
      end
      if (d == 6) begin
        checkOutput("t4_wdata", 0, rf_wdata[0], 20);
        checkOutput("t4_waddr", 0, rf_waddr[0], 7);
      end
    end

    // 100 x 100: dut1 times out after 8 BUSY cycles, dut0 completes
    step(); applyStimulus(1, 100, 100, 0, 1);
    for (int d = 0; d <= 104; d++) begin
      if (d > 0) step();
      if (d == 1) start = 1'b0;
      @(negedge clk);
      if (d == 9) begin
        checkOutput("t5_to_err", 1, err[1], 1);
        checkOutput("t5_to_we", 1, rf_we[1], 0);
        checkOutput("t5_to_stall", 1, stall[1], 0);
      end
      if (d == 102) begin
        checkOutput("t5_long_we", 0, rf_we[0], 1);
        checkOutput("t5_long_wdata", 0, rf_wdata[0], 10000);
        checkOutput("t5_long_err", 0, err[0], 0);
      end
    end

    // 2 x 2 afterwards: result retires, err stays sticky on dut1
    step(); applyStimulus(1, 2, 2, 0, 2);
    for (int d = 0; d <= 5; d++) begin
      if (d > 0) step();
      if (d == 1) start = 1'b0;
      @(negedge clk);
      if (d == 4) begin
        checkOutput("t5b_we", 1, rf_we[1], 1);
        checkOutput("t5b_wdata", 1, rf_wdata[1], 4);
        checkOutput("t5b_sticky", 1, err[1], 1);
      end
    end

    // 50 x 50 with reset in the second BUSY cycle
    step(); applyStimulus(1, 50, 50, 0, 4);
    for (int d = 0; d <= 6; d++) begin
      if (d > 0) step();
      if (d == 1) start = 1'b0;
      if (d == 2) rst = 1'b1;
      if (d == 3) rst = 1'b0;
      @(negedge clk);
      if (d == 3) begin
        for (int i = 0; i < 2; i++) begin
          checkOutput("t6_stall", i, stall[i], 0);
          checkOutput("t6_mul_a", i, mul_a[i], 0);
          checkOutput("t6_mul_b", i, mul_b[i], 0);
          checkOutput("t6_we", i, rf_we[i], 0);
        end
        checkOutput("t6_err_clr", 1, err[1], 0);
      end
    end

    step(); step();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
